// File: rtl/carry_skip_adder_pipe.sv
// Pipelined carry-skip adder: each stage adds one WIDTH/STAGES segment and forwards the carry.
// Define CSA_PIPE_OVF_EN to add the signed-overflow output ovf.
module carry_skip_adder_pipe #(
   parameter int WIDTH  = 32,
   parameter int BLK    = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef CSA_PIPE_OVF_EN
   ,
   output logic             ovf
`endif
);

   if (BLK < 1 || STAGES < 1 || (WIDTH % (BLK * STAGES)) != 0) begin : g_param_check
      $error("carry_skip_adder_pipe: WIDTH must be a multiple of BLK*STAGES, BLK and STAGES >= 1");
   end

   localparam int SEG = WIDTH / STAGES;
   localparam int NB  = SEG / BLK;

   logic advance;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   for (genvar k = 0; k < STAGES; k++) begin : g_stg
      // Operand bits of this segment and every later one still travel with the data.
      localparam int REM = WIDTH - k * SEG;

      logic [REM-1:0]         in_a;
      logic [REM-1:0]         in_b;
      logic                   in_c;
      logic                   in_v;
      logic [SEG-1:0]         seg_s;
      logic                   seg_co;
      logic [(k+1)*SEG-1:0]   sum_d;
      logic [(k+1)*SEG-1:0]   sum_q;
      logic                   v_q;
      logic                   c_q;

      if (k == 0) begin : g_src
         assign in_a  = a;
         assign in_b  = b;
         assign in_c  = cin;
         assign in_v  = in_valid && in_ready;
         assign sum_d = seg_s;
      end else begin : g_src
         assign in_a  = g_stg[k-1].g_ops.a_q;
         assign in_b  = g_stg[k-1].g_ops.b_q;
         assign in_c  = g_stg[k-1].c_q;
         assign in_v  = g_stg[k-1].v_q;
         assign sum_d = {seg_s, g_stg[k-1].sum_q};
      end

      // Block carry bypasses the ripple chain when every bit propagates.
      always_comb begin
         logic c;
         logic rc;
         logic p;
         logic p_all;
         c      = in_c;
         rc     = 1'b0;
         p      = 1'b0;
         p_all  = 1'b1;
         seg_s  = '0;
         for (int j = 0; j < NB; j++) begin
            p_all = 1'b1;
            rc    = c;
            for (int i = 0; i < BLK; i++) begin
               p                = in_a[j*BLK+i] ^ in_b[j*BLK+i];
               seg_s[j*BLK+i]   = p ^ rc;
               rc               = (in_a[j*BLK+i] & in_b[j*BLK+i]) | (p & rc);
               p_all            = p_all & p;
            end
            c = p_all ? c : rc;
         end
         seg_co = c;
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            v_q   <= 1'b0;
            sum_q <= '0;
            c_q   <= 1'b0;
         end else if (advance) begin
            v_q   <= in_v;
            sum_q <= sum_d;
            c_q   <= seg_co;
         end
      end

      if (k < STAGES - 1) begin : g_ops
         logic [REM-SEG-1:0] a_q;
         logic [REM-SEG-1:0] b_q;

         always_ff @(posedge clk) begin
            if (advance) begin
               a_q <= in_a[REM-1:SEG];
               b_q <= in_b[REM-1:SEG];
            end
         end
      end
   end

   assign out_valid = g_stg[STAGES-1].v_q;
   assign sum       = g_stg[STAGES-1].sum_q;
   assign cout      = g_stg[STAGES-1].c_q;

`ifdef CSA_PIPE_OVF_EN
   logic ovf_q;
   logic sa;
   logic sb;
   logic ss;

   // The last stage still holds the top operand bits, so the sign test needs no extra pipeline.
   assign sa = g_stg[STAGES-1].in_a[SEG-1];
   assign sb = g_stg[STAGES-1].in_b[SEG-1];
   assign ss = g_stg[STAGES-1].seg_s[SEG-1];

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_q <= 1'b0;
      end else if (advance) begin
         ovf_q <= (sa == sb) && (ss != sa);
      end
   end

   assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_carry_skip_adder_pipe.sv
// Bench for carry_skip_adder_pipe: directed steps plus random traffic on three configurations,
// each scored against plain a+b+cin arithmetic.
module tb_carry_skip_adder_pipe;

`ifdef CSA_PIPE_OVF_EN
   localparam bit HAS_OVF = 1'b1;
`else
   localparam bit HAS_OVF = 1'b0;
`endif

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        cin;

   logic [2:0]  ir;
   logic [2:0]  ov;
   logic [31:0] sum0;
   logic [15:0] sum1;
   logic [7:0]  sum2;
   logic        cout0, cout1, cout2;
   logic        ovf0, ovf1, ovf2;
   logic [33:0] got [3];

   int          errors = 0;
   int          checks = 0;
   int          acc0   = 0;
   int          wid [3] = '{32, 16, 8};
   logic [33:0] sb [3][$];

   carry_skip_adder_pipe #(.WIDTH(32), .BLK(4), .STAGES(2)) u0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[0]),
      .a(a), .b(b), .cin(cin), .out_valid(ov[0]), .out_ready(out_ready),
      .sum(sum0), .cout(cout0)
`ifdef CSA_PIPE_OVF_EN
      , .ovf(ovf0)
`endif
   );

   carry_skip_adder_pipe #(.WIDTH(16), .BLK(2), .STAGES(4)) u1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[1]),
      .a(a[15:0]), .b(b[15:0]), .cin(cin), .out_valid(ov[1]), .out_ready(out_ready),
      .sum(sum1), .cout(cout1)
`ifdef CSA_PIPE_OVF_EN
      , .ovf(ovf1)
`endif
   );

   carry_skip_adder_pipe #(.WIDTH(8), .BLK(8), .STAGES(1)) u2 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir[2]),
      .a(a[7:0]), .b(b[7:0]), .cin(cin), .out_valid(ov[2]), .out_ready(out_ready),
      .sum(sum2), .cout(cout2)
`ifdef CSA_PIPE_OVF_EN
      , .ovf(ovf2)
`endif
   );

`ifndef CSA_PIPE_OVF_EN
   assign ovf0 = 1'b0;
   assign ovf1 = 1'b0;
   assign ovf2 = 1'b0;
`endif

   assign got[0] = {ovf0, cout0, sum0};
   assign got[1] = {ovf1, cout1, 16'h0, sum1};
   assign got[2] = {ovf2, cout2, 24'h0, sum2};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {ovf, cout, sum zero-extended to 32 bits} for a w-bit adder.
   function automatic logic [33:0] model(input int w, input logic [31:0] x,
                                         input logic [31:0] y, input logic c);
      longint unsigned m;
      longint unsigned s;
      logic [31:0]     sx;
      logic            co;
      logic            o;
      m  = (64'd1 << w) - 64'd1;
      s  = (64'(x) & m) + (64'(y) & m) + 64'(c);
      sx = 32'(s & m);
      co = ((s >> w) & 64'd1) != 64'd0;
      o  = HAS_OVF && (x[w-1] == y[w-1]) && (sx[w-1] != x[w-1]);
      return {o, co, sx};
   endfunction

   task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [31:0] x, input logic [31:0] y, input logic c);
      in_valid = v;
      a        = x;
      b        = y;
      cin      = c;
   endtask

   // Scores transfers that the coming edge will perform, then advances one clock.
   task automatic cycle();
      #1;
      if (!rst) begin
         for (int i = 0; i < 3; i++) begin
            if (ov[i] && out_ready) begin
               if (sb[i].size() == 0) begin
                  checks++;
                  errors++;
                  $error("FAIL sb%0d_spurious observed=result expected=none pending", i);
               end else begin
                  chk($sformatf("sb%0d_result", i), got[i], sb[i].pop_front());
               end
            end
            if (in_valid && ir[i]) begin
               sb[i].push_back(model(wid[i], a, b, cin));
               if (i == 0) acc0++;
            end
         end
      end
      @(posedge clk);
      #1;
      if (rst) begin
         for (int i = 0; i < 3; i++) sb[i].delete();
      end
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h7FFF_FFFF;
         3:       return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      rst       = 1'b1;
      out_ready = 1'b0;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      cycle();
      cycle();
      rst = 1'b0;
      #1;
      chk("rst_out_valid", 34'(ov[0]), 34'd0);
      chk("rst_sum_cout", got[0], 34'd0);
      chk("rst_in_ready", 34'(ir[0]), 34'd1);

      // full skip path through every block
      out_ready = 1'b1;
      drive(1'b1, 32'hFFFF_FFFF, 32'h0, 1'b1);
      cycle();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      chk("skip_latency1", 34'(ov[0]), 34'd0);
      cycle();
      chk("skip_out_valid", 34'(ov[0]), 34'd1);
      chk("skip_sum_cout", 34'({cout0, sum0}), {2'b01, 32'h0});
      cycle();
      cycle();

      // back-to-back transfers
      drive(1'b1, 32'd1, 32'd2, 1'b0);
      cycle();
      drive(1'b1, 32'h8000_0000, 32'h8000_0000, 1'b0);
      cycle();
      chk("b2b0_sum_cout", 34'({ov[0], cout0, sum0}), {1'b0, 1'b1, 1'b0, 32'd3});
      chk("b2b0_ovf", 34'(ovf0), 34'd0);
      drive(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0);
      cycle();
      chk("b2b1_sum_cout", 34'({ov[0], cout0, sum0}), {1'b0, 1'b1, 1'b1, 32'h0});
      chk("b2b1_ovf", 34'(ovf0), 34'(HAS_OVF));
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      cycle();
      chk("b2b2_sum_cout", 34'({ov[0], cout0, sum0}), {1'b0, 1'b1, 1'b0, 32'h8000_0000});
      chk("b2b2_ovf", 34'(ovf0), 34'(HAS_OVF));
      cycle();
      cycle();
      cycle();

      // stall with a full pipe
      drive(1'b1, 32'd10, 32'd20, 1'b0);
      cycle();
      drive(1'b1, 32'd100, 32'd200, 1'b1);
      cycle();
      out_ready = 1'b0;
      drive(1'b1, 32'd5, 32'd5, 1'b0);
      #1;
      chk("stall_in_ready", 34'(ir[0]), 34'd0);
      for (int n = 0; n < 5; n++) begin
         cycle();
         chk($sformatf("stall_hold%0d", n), 34'({ov[0], ir[0], sum0}), {1'b0, 1'b1, 1'b0, 32'd30});
      end
      out_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      cycle();
      chk("drain_b", 34'({ov[0], sum0}), {1'b0, 1'b1, 32'd301});
      cycle();
      chk("drain_empty", 34'(ov[0]), 34'd0);
      cycle();
      cycle();

      // bubble pattern 1,0,1
      drive(1'b1, 32'd7, 32'd8, 1'b0);
      cycle();
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      cycle();
      chk("bubble_v0", 34'({ov[0], sum0}), {1'b0, 1'b1, 32'd15});
      drive(1'b1, 32'd9, 32'd9, 1'b1);
      cycle();
      chk("bubble_v1", 34'(ov[0]), 34'd0);
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      cycle();
      chk("bubble_v2", 34'({ov[0], sum0}), {1'b0, 1'b1, 32'd19});
      cycle();
      cycle();
      cycle();

      // reset with two results in flight and an operand offered in the reset cycle
      out_ready = 1'b0;
      drive(1'b1, 32'd1, 32'd1, 1'b0);
      cycle();
      drive(1'b1, 32'd2, 32'd2, 1'b0);
      cycle();
      rst = 1'b1;
      drive(1'b1, 32'd3, 32'd3, 1'b0);
      cycle();
      chk("midrst_out", 34'({ov[0], cout0, sum0}), 34'd0);
      rst       = 1'b0;
      out_ready = 1'b1;
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      for (int n = 0; n < 4; n++) begin
         cycle();
         chk($sformatf("midrst_stale%0d", n), 34'(ov), 34'd0);
      end

      // random traffic on all three configurations
      acc0 = 0;
      for (int cyc = 0; cyc < 40000 && acc0 < 10000; cyc++) begin
         drive($urandom_range(0, 9) != 0, pick(), pick(), 1'($urandom_range(0, 1)));
         out_ready = $urandom_range(0, 3) != 0;
         cycle();
      end
      chk("rand_accept_count", 34'(acc0 >= 10000), 34'd1);
      drive(1'b0, 32'h0, 32'h0, 1'b0);
      out_ready = 1'b1;
      for (int n = 0; n < 8; n++) cycle();
      for (int i = 0; i < 3; i++) chk($sformatf("sb%0d_drained", i), 34'(sb[i].size()), 34'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/carry_skip_adder_pipe.md
CARRY_SKIP_ADDER_PIPE -- requirements
Module: carry_skip_adder_pipe

Interface
REQ-001 Parameters SHALL be (name, default, meaning): WIDTH, 32, operand/sum width in bits.
REQ-002 BLK, 4, carry-skip block size in bits.
REQ-003 STAGES, 2, number of pipeline stages; each stage owns WIDTH/STAGES contiguous bits, LSB segment first.
REQ-004 Ports SHALL be (name, direction, width, meaning): clk, input, 1, sole clock; all state on rising edge.
REQ-005 rst, input, 1, synchronous active-high reset.
REQ-006 in_valid, input, 1, operands a, b, cin present.
REQ-007 in_ready, output, 1, block accepts operands this cycle.
REQ-008 a, input, WIDTH, first unsigned operand.
REQ-009 b, input, WIDTH, second unsigned operand.
REQ-010 cin, input, 1, carry in.
REQ-011 out_valid, output, 1, sum/cout valid.
REQ-012 out_ready, input, 1, downstream accepts result.
REQ-013 sum, output, WIDTH, (a + b + cin) mod 2^WIDTH.
REQ-014 cout, output, 1, carry out of bit WIDTH-1.
REQ-015 One clock; reset SHALL be synchronous and active-high.

Function
REQ-016 Elaboration SHALL fail if WIDTH mod (BLK*STAGES) != 0, or if BLK < 1 or STAGES < 1.
REQ-017 Each segment SHALL be a chain of BLK-bit blocks; a block's carry out SHALL be its carry in when all BLK bit propagates (a^b) are 1, else its internal ripple carry.
REQ-018 Stage k SHALL register: valid bit, sum bits of segments 0..k, carry out of segment k, and undelayed-yet operand bits of segments k+1..STAGES-1.
REQ-019 Global advance SHALL be advance = !out_valid || out_ready; all stage registers load only when advance = 1.
REQ-020 in_ready SHALL equal advance (combinational); a transfer occurs when in_valid && in_ready.
REQ-021 Latency SHALL be exactly STAGES cycles from input transfer to out_valid with no stall; throughput one result per cycle.
REQ-022 Stage 0 valid SHALL load in_valid && in_ready on advance; bubbles SHALL propagate as valid = 0 with data don't-care.
REQ-023 While out_valid && !out_ready, sum, cout, out_valid and all stage contents SHALL hold unchanged; no result dropped or duplicated.
REQ-024 Simultaneous output transfer and input transfer in one cycle SHALL be legal; pipeline shifts by one.
REQ-025 Results SHALL emerge in acceptance order.
REQ-026 Overflow beyond WIDTH SHALL wrap: sum is low WIDTH bits, cout carries bit WIDTH.

Reset
REQ-027 On rst = 1 at a rising edge, all stage valid bits and out_valid SHALL clear to 0; sum SHALL clear to 0, cout to 0.
REQ-028 Reset mid-operation SHALL discard all in-flight results; no result accepted before reset appears afterwards.
REQ-029 in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-030 rst SHALL take priority over a concurrent input transfer; operands presented in the reset cycle are discarded.

Configuration
REQ-031 Macro CSA_PIPE_OVF_EN SHALL, when defined, add output ovf (1 bit): signed two's-complement overflow, (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]), aligned with sum, reset 0, held under stall.
REQ-032 Without CSA_PIPE_OVF_EN, port ovf and its logic SHALL be absent; all other behaviour identical.

Verification
REQ-033 Defaults, out_ready = 1: a = 0xFFFFFFFF, b = 0x00000000, cin = 1 (full skip path) -> 2 cycles later sum = 0x00000000, cout = 1.
REQ-034 Back-to-back: 3 consecutive transfers (1+2+0, 0x80000000+0x80000000+0, 0x7FFFFFFF+1+0) -> sums 3/0/0x80000000, couts 0/1/0 on consecutive cycles; with OVF_EN ovf = 0/1/1.
REQ-035 Stall: fill pipe, out_ready = 0 for 5 cycles -> in_ready = 0, out_valid and sum held; release -> results drain in order, none lost.
REQ-036 Bubble: in_valid pattern 1,0,1 -> out_valid pattern 1,0,1 after 2-cycle latency.
REQ-037 Reset with 2 results in flight -> next cycle out_valid = 0, sum = 0; no stale result ever appears.
REQ-038 Random 10k transactions, WIDTH/BLK/STAGES in {(32,4,2),(16,2,4),(8,8,1)}, random out_ready -> scoreboard matches a+b+cin exactly.
